// File: rtl/dct_transpose_buf.sv
// Ping-pong 16x16 transpose buffer between the row DCT and column DCT stages.
// Rows fill one bank while the other bank drains column by column.
module dct_transpose_buf #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 11
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [N*W-1:0]         in_row,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [N*W-1:0]         out_col,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int unsigned AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [N*W-1:0] mem_q [2][N];

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
  logic [AW-1:0] rd_cnt_q,  rd_cnt_d;
  logic [1:0]    full_q,    full_d;

  logic wr_acc, rd_acc;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_idx   = rd_cnt_q;
  assign out_last  = out_valid && (rd_cnt_q == LAST);

  assign wr_acc = in_valid && in_ready;
  assign rd_acc = out_valid && out_ready;

  // Set and clear never hit the same bank: a write needs the bank empty, a read needs it full.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = '0;
      end
    end
    if (rd_acc) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wr_acc) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_row;
    end
  end

  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int unsigned r = 0; r < N; r++) begin
        out_col[r*W +: W] = mem_q[rd_bank_q][AW'(r)][rd_cnt_q*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Bench for dct_transpose_buf: ramp vector table, then randomized traffic vs a block/queue model.
module tb_dct_transpose_buf;

  localparam int N  = 16;
  localparam int W  = 11;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_valid;
  logic [N*W-1:0] in_row;
  logic           in_ready;
  logic           out_valid;
  logic [N*W-1:0] out_col;
  logic [AW-1:0]  out_idx;
  logic           out_last;
  logic           out_ready;

  always #5 clk = ~clk;

  dct_transpose_buf #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_row    (in_row),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: every accepted row in order, and the number of columns taken so far.
  logic [N*W-1:0] rows_q[$];
  int             cols_out;

  typedef struct {
    logic           iv;
    logic [N*W-1:0] row;
    logic           ordy;
    logic           e_ready;
    logic           e_valid;
    logic [AW-1:0]  e_idx;
    logic           e_last;
    logic [N*W-1:0] e_col;
  } vec_t;

  vec_t tbl[2*N];

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] ramp_row(input int r);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 11'(r*16 + k);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return 11'h400;
      1:       return 11'h3FF;
      default: return 11'($urandom);
    endcase
  endfunction

  function automatic logic [N*W-1:0] rand_row();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = rand_lane();
    return v;
  endfunction

  task automatic model_reset();
    rows_q.delete();
    cols_out = 0;
  endtask

  // One cycle: drive, check outputs against the model, advance the model at the edge.
  task automatic step(input logic rv, input logic iv, input logic [N*W-1:0] row, input logic ordy);
    int             blocks_full;
    logic           m_ready, m_valid;
    logic [N*W-1:0] m_col;
    int             b, c;
    rstn = rv; in_valid = iv; in_row = row; out_ready = ordy;
    @(negedge clk);
    blocks_full = rows_q.size() / N - cols_out / N;
    m_ready = blocks_full < 2;
    m_valid = blocks_full > 0;
    b = cols_out / N;
    c = cols_out % N;
    m_col = '0;
    if (m_valid)
      for (int r = 0; r < N; r++) m_col[r*W +: W] = rows_q[b*N + r][c*W +: W];
    chk("in_ready",  {{(N*W-1){1'b0}}, in_ready},  {{(N*W-1){1'b0}}, m_ready});
    chk("out_valid", {{(N*W-1){1'b0}}, out_valid}, {{(N*W-1){1'b0}}, m_valid});
    chk("out_idx",   {{(N*W-AW){1'b0}}, out_idx},  {{(N*W-AW){1'b0}}, AW'(c)});
    chk("out_last",  {{(N*W-1){1'b0}}, out_last},  {{(N*W-1){1'b0}}, m_valid && c == N-1});
    chk("out_col",   out_col, m_col);
    if (!rv) model_reset();
    else begin
      if (iv && m_ready) rows_q.push_back(row);
      if (m_valid && ordy) cols_out++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    rstn = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    hard_reset();

    // Ramp block: table of fill then drain with fixed expectations.
    for (int i = 0; i < 2*N; i++) begin
      tbl[i].iv      = (i < N);
      tbl[i].row     = (i < N) ? ramp_row(i) : '0;
      tbl[i].ordy    = (i >= N);
      tbl[i].e_ready = 1'b1;
      tbl[i].e_valid = (i >= N);
      tbl[i].e_idx   = (i >= N) ? AW'(i - N) : '0;
      tbl[i].e_last  = (i == 2*N-1);
      tbl[i].e_col   = '0;
      if (i >= N)
        for (int r = 0; r < N; r++) tbl[i].e_col[r*W +: W] = 11'(r*16 + (i - N));
    end
    rstn = 1'b1;
    for (int i = 0; i < 2*N; i++) begin
      in_valid = tbl[i].iv; in_row = tbl[i].row; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk("tbl_in_ready",  {{(N*W-1){1'b0}}, in_ready},  {{(N*W-1){1'b0}}, tbl[i].e_ready});
      chk("tbl_out_valid", {{(N*W-1){1'b0}}, out_valid}, {{(N*W-1){1'b0}}, tbl[i].e_valid});
      chk("tbl_out_idx",   {{(N*W-AW){1'b0}}, out_idx},  {{(N*W-AW){1'b0}}, tbl[i].e_idx});
      chk("tbl_out_last",  {{(N*W-1){1'b0}}, out_last},  {{(N*W-1){1'b0}}, tbl[i].e_last});
      chk("tbl_out_col",   out_col, tbl[i].e_col);
      @(posedge clk);
      #1;
    end

    // Streaming: four back-to-back blocks of extremes and random values.
    hard_reset();
    for (int i = 0; i < 4*N; i++) step(1'b1, 1'b1, rand_row(), 1'b1);
    for (int i = 0; i < N + 2; i++) step(1'b1, 1'b0, '0, 1'b1);
    chk("stream_cols", 32'(cols_out), 32'(4*N));

    // Backpressure: 40 rows offered with the output stalled, then drain.
    hard_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, rand_row(), 1'b0);
    chk("bp_accepted", 32'(rows_q.size()), 32'(2*N));
    chk("bp_in_ready_low", {{(N*W-1){1'b0}}, in_ready}, '0);
    for (int i = 0; i < 2*N + 2; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Gaps: random in_valid and out_ready.
    hard_reset();
    for (int i = 0; i < 600; i++)
      step(1'b1, 1'($urandom_range(0, 1)), rand_row(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3*N; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Reset mid-operation: block 1 has 7 rows, block 0 half drained.
    hard_reset();
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, rand_row(), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, rand_row(), 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("rst_out_valid", {{(N*W-1){1'b0}}, out_valid}, '0);
    chk("rst_out_col", out_col, '0);
    chk("rst_in_ready", {{(N*W-1){1'b0}}, in_ready}, {{(N*W-1){1'b0}}, 1'b1});
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, ramp_row(i), 1'b0);
    for (int i = 0; i < N + 2; i++) step(1'b1, 1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
